// File: rtl/v1_peak_detector_pkg.sv
// v1_peak_detector_pkg: sample width, detector defaults and the detector FSM state type.
package v1_peak_detector_pkg;
    localparam int SIZE_FILTER_DATA = 16;
    localparam int V1_THRESHOLD     = 100;
    localparam int V1_HYST          = 10;
    localparam int V1_HOLDOFF       = 4;
    localparam int V1_MAX_WIDTH     = 64;
    localparam int V1_TIME_WIDTH    = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_HOLDOFF} v1_pd_state_t;
endpackage

// File: rtl/v1_event_slot.sv
// v1_event_slot: single-entry valid/ready event register; events arriving while it is
// occupied and not being drained are dropped and counted (saturating).
module v1_event_slot
    import v1_peak_detector_pkg::*;
#(
    parameter int TW = V1_TIME_WIDTH,
    parameter int WB = 7
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               emit_i,
    input  logic signed [SIZE_FILTER_DATA-1:0] amp_i,
    input  logic        [TW-1:0]               time_i,
    input  logic        [WB-1:0]               width_i,
    input  logic                               pileup_i,
    input  logic                               ready_i,
    output logic                               valid_o,
    output logic signed [SIZE_FILTER_DATA-1:0] amp_o,
    output logic        [TW-1:0]               time_o,
    output logic        [WB-1:0]               width_o,
    output logic                               pileup_o,
    output logic        [15:0]                 lost_o
);
    logic                               valid_q, pileup_q;
    logic signed [SIZE_FILTER_DATA-1:0] amp_q;
    logic        [TW-1:0]               time_q;
    logic        [WB-1:0]               width_q;
    logic        [15:0]                 lost_q;
    logic                               full, load;

    assign full = valid_q & ~ready_i;
    assign load = emit_i & ~full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            amp_q    <= '0;
            time_q   <= '0;
            width_q  <= '0;
            pileup_q <= 1'b0;
            lost_q   <= '0;
        end else begin
            if (load) begin
                valid_q  <= 1'b1;
                amp_q    <= amp_i;
                time_q   <= time_i;
                width_q  <= width_i;
                pileup_q <= pileup_i;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            if (emit_i && full && lost_q != 16'hFFFF)
                lost_q <= lost_q + 16'd1;
        end
    end

    assign valid_o  = valid_q;
    assign amp_o    = amp_q;
    assign time_o   = time_q;
    assign width_o  = width_q;
    assign pileup_o = pileup_q;
    assign lost_o   = lost_q;
endmodule

// File: rtl/v1_peak_detector.sv
// v1_peak_detector: threshold/hysteresis pulse detector capturing peak amplitude,
// peak timestamp and width per pulse, with pile-up cut-off and post-event holdoff.
module v1_peak_detector
    import v1_peak_detector_pkg::*;
#(
    parameter int THRESHOLD  = V1_THRESHOLD,
    parameter int HYST       = V1_HYST,
    parameter int HOLDOFF    = V1_HOLDOFF,
    parameter int MAX_WIDTH  = V1_MAX_WIDTH,
    parameter int TIME_WIDTH = V1_TIME_WIDTH,
    localparam int WIDTH_BITS = $clog2(MAX_WIDTH + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    output logic                               peak_valid,
    input  logic                               peak_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
    output logic        [TIME_WIDTH-1:0]       peak_time,
    output logic        [WIDTH_BITS-1:0]       peak_width,
    output logic                               peak_pileup,
    output logic        [15:0]                 lost_count
);
    localparam int HCW = $clog2(HOLDOFF + 2);
    // One extra bit so THRESHOLD-HYST never wraps against the sample range
    localparam logic signed [SIZE_FILTER_DATA:0] TH_X = (SIZE_FILTER_DATA+1)'(THRESHOLD);
    localparam logic signed [SIZE_FILTER_DATA:0] LO_X = (SIZE_FILTER_DATA+1)'(THRESHOLD - HYST);
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);

    v1_pd_state_t                       state_q;
    logic signed [SIZE_FILTER_DATA-1:0] d_q, max_q;
    logic signed [SIZE_FILTER_DATA:0]   d_x;
    logic        [TIME_WIDTH-1:0]       time_q, ts_q, max_time_q;
    logic        [WIDTH_BITS-1:0]       width_q;
    logic        [HCW-1:0]              hold_q;
    logic                               low, at_max, emit;

    assign d_x    = {d_q[SIZE_FILTER_DATA-1], d_q};
    assign low    = d_x < LO_X;
    assign at_max = width_q == WIDTH_BITS'(MAX_WIDTH);
    assign emit   = (state_q == ST_TRACK) && (low || at_max);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            d_q        <= '0;
            time_q     <= '0;
            ts_q       <= '0;
            max_q      <= '0;
            max_time_q <= '0;
            width_q    <= '0;
            hold_q     <= '0;
        end else begin
            d_q    <= filter_data;
            ts_q   <= time_q;
            time_q <= time_q + TIME_WIDTH'(1);
            case (state_q)
                ST_IDLE: if (d_x > TH_X) begin
                    state_q    <= ST_TRACK;
                    max_q      <= d_q;
                    max_time_q <= ts_q;
                    width_q    <= WIDTH_BITS'(1);
                end
                ST_TRACK: if (emit) begin
                    state_q <= ST_HOLDOFF;
                    hold_q  <= HOLD_INIT;
                end else begin
                    width_q <= width_q + WIDTH_BITS'(1);
                    if (d_q > max_q) begin
                        max_q      <= d_q;
                        max_time_q <= ts_q;
                    end
                end
                // Leaving holdoff also requires the signal to be low, so pile-up cannot retrigger
                ST_HOLDOFF: if (hold_q != '0) hold_q <= hold_q - HCW'(1);
                            else if (low) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    v1_event_slot #(.TW(TIME_WIDTH), .WB(WIDTH_BITS)) u_slot (
        .clk      (clk),
        .reset    (reset),
        .emit_i   (emit),
        .amp_i    (max_q),
        .time_i   (max_time_q),
        .width_i  (width_q),
        .pileup_i (~low),
        .ready_i  (peak_ready),
        .valid_o  (peak_valid),
        .amp_o    (peak_amplitude),
        .time_o   (peak_time),
        .width_o  (peak_width),
        .pileup_o (peak_pileup),
        .lost_o   (lost_count)
    );
endmodule
